regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port among NUM_REQ writeback sources (e.g. ALU, load unit, mul/div).

---
 rtl/regfile_wb_arbiter_pkg.sv | 17 +
 rtl/regfile_wb_arbiter_if.sv | 31 +++
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 39 +++
 rtl/regfile_wb_arbiter.sv | 65 ++++++
 tb/tb_regfile_wb_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Core-wide widths and writeback requester IDs shared by the register file
// writeback path and its sources.
package rv_core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam int WB_ALU = 0;
  localparam int WB_LSU = 1;
  localparam int WB_MDU = 2;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback sources on one side (valid/ready per requester, hold, busy) and
// the register file write port triple on the other.
interface regfile_wb_arbiter_if
  import rv_core_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = XLEN,
  parameter int ADDR_W  = REG_ADDR_W
);

  logic                      wb_hold;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_rd;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      busy;
  logic                      RegWrite;
  logic [ADDR_W-1:0]         Rd;
  logic [DATA_W-1:0]         write_data;

  modport master (
    output wb_hold, req_valid, req_rd, req_data,
    input  req_ready, busy, RegWrite, Rd, write_data
  );

  modport slave (
    input  wb_hold, req_valid, req_rd, req_data,
    output req_ready, busy, RegWrite, Rd, write_data
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin pick: first set req bit after ptr, wrapping; purely combinational,
// zero latency; en=0 grants nothing.
module rr_arbiter
  import rv_core_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic found;

  // Two passes: indices above ptr first, then wrap around to 0..ptr.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (en && !found && req[i] && (IW'(i) > ptr)) begin
        gnt[i]  = 1'b1;
        gnt_idx = IW'(i);
        found   = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (en && !found && req[i] && (IW'(i) <= ptr)) begin
        gnt[i]  = 1'b1;
        gnt_idx = IW'(i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the register file write port; 1-cycle handshake-to-RegWrite,
// one grant per cycle, wb_hold or reset stalls every requester.
module regfile_wb_arbiter
  import rv_core_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = XLEN,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_wb_arbiter_if.slave   bus
);

  localparam int PW = idx_width(NUM_REQ);

  logic [PW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] gnt;
  logic [PW-1:0]      gnt_idx;
  logic               gnt_vld;
  logic [ADDR_W-1:0]  sel_rd;
  logic [DATA_W-1:0]  sel_data;

  // Reset gates the grant so no source sees ready while the port is cleared.
  rr_arbiter #(.N(NUM_REQ), .IW(PW)) u_rr (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .en      (!bus.wb_hold && reset),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign gnt_vld       = |gnt;
  assign bus.req_ready = gnt;
  assign bus.busy      = |(bus.req_valid & ~gnt);

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_rd   = bus.req_rd[i*ADDR_W +: ADDR_W];
        sel_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // x0 writes complete the handshake and move the pointer but never assert RegWrite.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.RegWrite   <= 1'b0;
      bus.Rd         <= '0;
      bus.write_data <= '0;
      rr_ptr         <= PW'(NUM_REQ - 1);
    end else if (gnt_vld) begin
      bus.RegWrite   <= (sel_rd != '0);
      bus.Rd         <= sel_rd;
      bus.write_data <= sel_data;
      rr_ptr         <= gnt_idx;
    end else begin
      bus.RegWrite   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed table of per-cycle vectors plus a mid-stream reset sequence,
// with a small register file model fed by the arbiter's write port.
module tb_regfile_wb_arbiter;
  import rv_core_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  regfile_wb_arbiter_if #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) bus ();

  regfile_wb_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model; its reset is the inverted arbiter reset.
  logic        rf_rst;
  logic [31:0] rf [32];
  assign rf_rst = ~reset;

  always_ff @(posedge clk or posedge rf_rst) begin
    if (rf_rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (bus.RegWrite && bus.Rd != 5'd0) begin
      rf[bus.Rd] <= bus.write_data;
    end
  end

  typedef struct {
    logic        hold;
    logic [2:0]  valid;
    logic [14:0] rd;
    logic [95:0] data;
    logic [2:0]  ready;
    logic        busy;
    logic        rw;
    logic [4:0]  rdo;
    logic [31:0] wd;
    logic        rf_chk;
    logic [4:0]  rf_idx;
    logic [31:0] rf_val;
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t mk(input logic hold, input logic [2:0] valid,
                              input logic [14:0] rd, input logic [95:0] data,
                              input logic [2:0] ready, input logic busy,
                              input logic rw, input logic [4:0] rdo, input logic [31:0] wd,
                              input logic rf_chk, input logic [4:0] rf_idx,
                              input logic [31:0] rf_val);
    vec_t v;
    v.hold = hold; v.valid = valid; v.rd = rd; v.data = data;
    v.ready = ready; v.busy = busy; v.rw = rw; v.rdo = rdo; v.wd = wd;
    v.rf_chk = rf_chk; v.rf_idx = rf_idx; v.rf_val = rf_val;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic hold, input logic [2:0] valid,
                       input logic [14:0] rd, input logic [95:0] data);
    bus.wb_hold   = hold;
    bus.req_valid = valid;
    bus.req_rd    = rd;
    bus.req_data  = data;
  endtask

  task automatic check_port(input string pfx, input logic rw, input logic [4:0] rdo,
                            input logic [31:0] wd);
    check({pfx, "_regwrite"}, 32'(bus.RegWrite), 32'(rw));
    check({pfx, "_rd"}, 32'(bus.Rd), 32'(rdo));
    check({pfx, "_wdata"}, bus.write_data, wd);
  endtask

  logic [14:0] rd_a, rd_b, rd_c, rd_d, rd_e, rd_f;
  logic [95:0] da_a, da_b, da_c, da_d, da_e, da_f;

  initial begin
    checks   = 0;
    failures = 0;
    rd_a = {5'd3, 5'd2, 5'd1};  da_a = {32'hA2, 32'hA1, 32'hA0};
    rd_b = {5'd3, 5'd5, 5'd1};  da_b = {32'hA2, 32'hDEADBEEF, 32'hA0};
    rd_c = {5'd3, 5'd6, 5'd0};  da_c = {32'hA2, 32'h66, 32'h1234};
    rd_d = {5'd7, 5'd0, 5'd7};  da_d = {32'hB, 32'h66, 32'hA};
    rd_e = {5'd7, 5'd8, 5'd9};  da_e = {32'hB, 32'h88, 32'h99};
    rd_f = {5'd12, 5'd11, 5'd10}; da_f = {32'hC2, 32'hC1, 32'hC0};

    // Round-robin 0,1,2,0 with all valid, then drain.
    tbl[0]  = mk(0, 3'b111, rd_a, da_a, 3'b001, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    tbl[1]  = mk(0, 3'b111, rd_a, da_a, 3'b010, 1, 1, 5'd1, 32'hA0, 0, 5'd0, 32'h0);
    tbl[2]  = mk(0, 3'b111, rd_a, da_a, 3'b100, 1, 1, 5'd2, 32'hA1, 0, 5'd0, 32'h0);
    tbl[3]  = mk(0, 3'b111, rd_a, da_a, 3'b001, 1, 1, 5'd3, 32'hA2, 0, 5'd0, 32'h0);
    tbl[4]  = mk(0, 3'b000, rd_a, da_a, 3'b000, 0, 1, 5'd1, 32'hA0, 0, 5'd0, 32'h0);
    tbl[5]  = mk(0, 3'b000, rd_a, da_a, 3'b000, 0, 0, 5'd1, 32'hA0, 1, 5'd3, 32'hA2);
    // Single requester 1 writing x5.
    tbl[6]  = mk(0, 3'b010, rd_b, da_b, 3'b010, 0, 0, 5'd1, 32'hA0, 0, 5'd0, 32'h0);
    tbl[7]  = mk(0, 3'b000, rd_b, da_b, 3'b000, 0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0);
    tbl[8]  = mk(0, 3'b000, rd_b, da_b, 3'b000, 0, 0, 5'd5, 32'hDEADBEEF, 1, 5'd5, 32'hDEADBEEF);
    // x0 write: handshake completes, no RegWrite, pointer moves to 0.
    tbl[9]  = mk(0, 3'b001, rd_c, da_c, 3'b001, 0, 0, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0);
    tbl[10] = mk(0, 3'b000, rd_c, da_c, 3'b000, 0, 0, 5'd0, 32'h1234, 1, 5'd0, 32'h0);
    tbl[11] = mk(0, 3'b011, rd_c, da_c, 3'b010, 1, 0, 5'd0, 32'h1234, 0, 5'd0, 32'h0);
    tbl[12] = mk(0, 3'b000, rd_c, da_c, 3'b000, 0, 1, 5'd6, 32'h66, 0, 5'd0, 32'h0);
    tbl[13] = mk(0, 3'b001, rd_c, da_c, 3'b001, 0, 0, 5'd6, 32'h66, 1, 5'd6, 32'h66);
    // Same-Rd collision with rr_ptr=0: req2 then req0, x7 ends at A.
    tbl[14] = mk(0, 3'b101, rd_d, da_d, 3'b100, 1, 0, 5'd0, 32'h1234, 0, 5'd0, 32'h0);
    tbl[15] = mk(0, 3'b001, rd_d, da_d, 3'b001, 0, 1, 5'd7, 32'hB, 0, 5'd0, 32'h0);
    tbl[16] = mk(0, 3'b000, rd_d, da_d, 3'b000, 0, 1, 5'd7, 32'hA, 0, 5'd0, 32'h0);
    tbl[17] = mk(0, 3'b010, rd_d, da_d, 3'b010, 0, 0, 5'd7, 32'hA, 1, 5'd7, 32'hA);
    // Hold three cycles with req0/req1 valid, then release.
    tbl[18] = mk(1, 3'b011, rd_e, da_e, 3'b000, 1, 0, 5'd0, 32'h66, 0, 5'd0, 32'h0);
    tbl[19] = mk(1, 3'b011, rd_e, da_e, 3'b000, 1, 0, 5'd0, 32'h66, 0, 5'd0, 32'h0);
    tbl[20] = mk(1, 3'b011, rd_e, da_e, 3'b000, 1, 0, 5'd0, 32'h66, 0, 5'd0, 32'h0);
    tbl[21] = mk(0, 3'b011, rd_e, da_e, 3'b001, 1, 0, 5'd0, 32'h66, 0, 5'd0, 32'h0);
    tbl[22] = mk(0, 3'b010, rd_e, da_e, 3'b010, 0, 1, 5'd9, 32'h99, 0, 5'd0, 32'h0);
    // Hold rises while a write is registered: that write still lands.
    tbl[23] = mk(1, 3'b000, rd_e, da_e, 3'b000, 0, 1, 5'd8, 32'h88, 1, 5'd9, 32'h99);
    tbl[24] = mk(0, 3'b000, rd_e, da_e, 3'b000, 0, 0, 5'd8, 32'h88, 1, 5'd8, 32'h88);

    reset = 1'b0;
    drive(0, 3'b111, rd_a, da_a);
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    check_port("rst", 0, 5'd0, 32'h0);

    @(negedge clk);
    drive(0, 3'b000, rd_a, da_a);
    reset = 1'b1;

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      drive(tbl[i].hold, tbl[i].valid, tbl[i].rd, tbl[i].data);
      #1;
      check($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(tbl[i].ready));
      check($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
      check_port($sformatf("v%0d", i), tbl[i].rw, tbl[i].rdo, tbl[i].wd);
      if (tbl[i].rf_chk)
        check($sformatf("v%0d_rf_x%0d", i, tbl[i].rf_idx), rf[tbl[i].rf_idx], tbl[i].rf_val);
    end

    // Reset lands right after a handshake edge mid-stream; rr_ptr is 1 here.
    @(negedge clk);
    drive(0, 3'b111, rd_f, da_f);
    #1;
    check("mid_ready_req2", 32'(bus.req_ready), 32'b100);
    @(posedge clk);
    #1;
    check_port("mid_req2_write", 1, 5'd12, 32'hC2);
    @(negedge clk);
    #1;
    check("mid_ready_req0", 32'(bus.req_ready), 32'b001);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_port("mid_rst_clear", 0, 5'd0, 32'h0);
    check("mid_rst_ready", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    #1;
    check_port("mid_rst_hold", 0, 5'd0, 32'h0);
    check("mid_rst_rf_x10", rf[10], 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("restart_ready_req0", 32'(bus.req_ready), 32'b001);
    check_port("restart_idle", 0, 5'd0, 32'h0);
    @(posedge clk);
    #1;
    check_port("restart_req0_write", 1, 5'd10, 32'hC0);
    @(negedge clk);
    drive(0, 3'b000, rd_f, da_f);
    @(negedge clk);
    #1;
    check(WB_ALU == 0 ? "restart_rf_x10" : "rf_x10", rf[10], 32'hC0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
